// File: rtl/fifo_pkg.sv
// Types and default sizes shared by the synchronous FIFO and its write-side feeders.
package fifo_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam int FIFO_WIDTH = 4;
  localparam int FIFO_DEPTH = 16;

endpackage

// File: rtl/fifo_wr_unpacker.sv
// Splits each accepted wide word into RATIO slices and writes them to the FIFO one per
// cycle, stalling on full; also keeps a sticky copy of the FIFO error flag.
module fifo_wr_unpacker
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int RATIO     = 4,
  parameter bit LSB_FIRST = 1'b1,
  localparam int IN_WIDTH  = WIDTH * RATIO,
  localparam int IDX_WIDTH = $clog2(RATIO)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 s_valid_i,
  input  logic [IN_WIDTH-1:0]  s_data_i,
  output logic                 s_ready_o,
  output logic                 wr_en_o,
  output logic [WIDTH-1:0]     wdata_o,
  input  logic                 full_i,
  input  logic                 error_i,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [IDX_WIDTH-1:0] slice_idx_o
);

  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(RATIO - 1);

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   hold_q, hold_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  err_q, err_d;
  logic [WIDTH-1:0]      slice_w [RATIO];

  // slice_w[n] is the n-th slice in write order, so the mux only needs idx.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    localparam int SRC = LSB_FIRST ? gi : (RATIO - 1 - gi);
    assign slice_w[gi] = hold_q[SRC*WIDTH +: WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    s_ready_o = 1'b0;
    wr_en_o   = 1'b0;
    wdata_o   = '0;
    unique case (state_q)
      ST_IDLE: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          hold_d  = s_data_i;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        wr_en_o = ~full_i;
        wdata_o = slice_w[idx_q];
        if (!full_i) begin
          if (idx_q == IDX_LAST) begin
            // Last slice leaves this cycle: take the next word with no bubble.
            s_ready_o = 1'b1;
            idx_d     = '0;
            if (s_valid_i) begin
              hold_d = s_data_i;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign err_d = err_q | error_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign busy_o      = (state_q == ST_SEND);
  assign slice_idx_o = idx_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_fifo_wr_unpacker.sv
// Self-checking bench: directed vector table, FIFO-integrated and reset sequences, and
// random traffic checked against a slice-queue reference model.
module tb_fifo_wr_unpacker;
  localparam int W = 4;
  localparam int R = 4;
  localparam int IW = W * R;
  localparam int XW = $clog2(R);
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, s_valid_i, full_i, error_i;
  logic [IW-1:0] s_data_i;
  logic          ready_l, wr_l, busy_l, err_l;
  logic [W-1:0]  wdata_l;
  logic [XW-1:0] idx_l;
  logic          ready_m, wr_m, busy_m, err_m;
  logic [W-1:0]  wdata_m;
  logic [XW-1:0] idx_m;

  fifo_wr_unpacker #(.WIDTH(W), .RATIO(R), .LSB_FIRST(1'b1)) dut_lsb (
    .clk_i(clk), .rst_i(rst_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
    .s_ready_o(ready_l), .wr_en_o(wr_l), .wdata_o(wdata_l), .full_i(full_i),
    .error_i(error_i), .busy_o(busy_l), .err_o(err_l), .slice_idx_o(idx_l));

  fifo_wr_unpacker #(.WIDTH(W), .RATIO(R), .LSB_FIRST(1'b0)) dut_msb (
    .clk_i(clk), .rst_i(rst_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
    .s_ready_o(ready_m), .wr_en_o(wr_m), .wdata_o(wdata_m), .full_i(full_i),
    .error_i(error_i), .busy_o(busy_m), .err_o(err_m), .slice_idx_o(idx_m));

  int n_cmp = 0;
  int n_bad = 0;
  int cycle_no = 0;

  // Reference model: slices still owed to the FIFO, in write order.
  logic [W-1:0] q_l[$];
  logic [W-1:0] q_m[$];
  logic         err_ref = 1'b0;
  bit           acc_last;
  // Behavioural FIFO used for the integrated test.
  bit           fifo_mode = 0;
  logic [W-1:0] fifo_q[$];
  logic         fifo_err = 1'b0;
  int           written = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle_no, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [IW-1:0] d,
                       input logic f, input logic e);
    rst_i = r; s_valid_i = v; s_data_i = d; full_i = f; error_i = e;
    #1;
  endtask

  task automatic check_model();
    bit busy;
    busy = (q_l.size() != 0);
    chk("busy", busy_l, busy);
    chk("busy_msb", busy_m, busy);
    chk("wr_en", wr_l, busy && !full_i);
    chk("wr_en_msb", wr_m, busy && !full_i);
    chk("wdata", wdata_l, busy ? q_l[0] : '0);
    chk("wdata_msb", wdata_m, busy ? q_m[0] : '0);
    chk("s_ready", ready_l, !busy || (q_l.size() == 1 && !full_i));
    chk("s_ready_msb", ready_m, !busy || (q_l.size() == 1 && !full_i));
    chk("slice_idx", idx_l, busy ? (R - q_l.size()) : 0);
    chk("err_o", err_l, err_ref);
  endtask

  task automatic advance();
    bit busy, wr, rdy;
    busy = (q_l.size() != 0);
    wr   = busy && !full_i;
    rdy  = !busy || (q_l.size() == 1 && !full_i);
    acc_last = 0;
    @(posedge clk);
    cycle_no++;
    if (rst_i) begin
      q_l.delete(); q_m.delete(); err_ref = 1'b0;
    end else begin
      if (error_i) err_ref = 1'b1;
      if (wr) begin
        if (fifo_mode) begin
          if (fifo_q.size() == DEPTH) fifo_err = 1'b1;
          else fifo_q.push_back(q_l[0]);
        end
        written++;
        void'(q_l.pop_front());
        void'(q_m.pop_front());
      end
      if (rdy && s_valid_i) begin
        acc_last = 1;
        $display("cycle %0d: word %h accepted", cycle_no, s_data_i);
        for (int k = 0; k < R; k++) begin
          q_l.push_back(s_data_i[k*W +: W]);
          q_m.push_back(s_data_i[(R-1-k)*W +: W]);
        end
      end
    end
    #1;
  endtask

  typedef struct {
    logic          v;
    logic [IW-1:0] d;
    logic          f;
    logic          rdy;
    logic          wr;
    logic [W-1:0]  wd_l;
    logic [W-1:0]  wd_m;
    logic          busy;
    logic [XW-1:0] idx;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [IW-1:0] d, logic f, logic rdy, logic wr,
                              logic [W-1:0] wl, logic [W-1:0] wm, logic b, logic [XW-1:0] x);
    vec_t t;
    t.v = v; t.d = d; t.f = f; t.rdy = rdy; t.wr = wr;
    t.wd_l = wl; t.wd_m = wm; t.busy = b; t.idx = x;
    return t;
  endfunction

  logic [IW-1:0] words[5];
  int            wi;
  logic [IW-1:0] w;

  initial begin
    // Single word A5C3.
    vecs.push_back(mk(1, 16'hA5C3, 0, 1, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 4'h3, 4'hA, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 4'hC, 4'h5, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 4'h5, 4'hC, 1, 2));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 4'hA, 4'h3, 1, 3));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 4'h0, 4'h0, 0, 0));
    // Back-to-back 1234 then 5678.
    vecs.push_back(mk(1, 16'h1234, 0, 1, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(1, 16'h5678, 0, 0, 1, 4'h4, 4'h1, 1, 0));
    vecs.push_back(mk(1, 16'h5678, 0, 0, 1, 4'h3, 4'h2, 1, 1));
    vecs.push_back(mk(1, 16'h5678, 0, 0, 1, 4'h2, 4'h3, 1, 2));
    vecs.push_back(mk(1, 16'h5678, 0, 1, 1, 4'h1, 4'h4, 1, 3));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 4'h8, 4'h5, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 4'h7, 4'h6, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 4'h6, 4'h7, 1, 2));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 4'h5, 4'h8, 1, 3));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 4'h0, 4'h0, 0, 0));
    // Backpressure on BEEF after the second slice.
    vecs.push_back(mk(1, 16'hBEEF, 0, 1, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 4'hF, 4'hB, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 4'hE, 4'hE, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 4'hE, 4'hE, 1, 2));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 4'hE, 4'hE, 1, 2));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 4'hE, 4'hE, 1, 2));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 4'hE, 4'hE, 1, 2));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 4'hB, 4'hF, 1, 3));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 4'h0, 4'h0, 0, 0));
    // Full on the last slice blocks the waiting word until it clears.
    vecs.push_back(mk(1, 16'h7E81, 0, 1, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(1, 16'h3C3C, 0, 0, 1, 4'h1, 4'h7, 1, 0));
    vecs.push_back(mk(1, 16'h3C3C, 0, 0, 1, 4'h8, 4'hE, 1, 1));
    vecs.push_back(mk(1, 16'h3C3C, 0, 0, 1, 4'hE, 4'h8, 1, 2));
    vecs.push_back(mk(1, 16'h3C3C, 1, 0, 0, 4'h7, 4'h1, 1, 3));
    vecs.push_back(mk(1, 16'h3C3C, 0, 1, 1, 4'h7, 4'h1, 1, 3));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 4'hC, 4'h3, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 4'h3, 4'hC, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 4'hC, 4'h3, 1, 2));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 4'h3, 4'hC, 1, 3));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 4'h0, 4'h0, 0, 0));

    // Reset and reset-state check.
    drive(1, 0, '0, 0, 0);
    advance();
    drive(0, 0, '0, 0, 0);
    chk("rst_ready", ready_l, 1);
    chk("rst_wr_en", wr_l, 0);
    chk("rst_wdata", wdata_l, 0);
    chk("rst_busy", busy_l, 0);
    chk("rst_idx", idx_l, 0);
    chk("rst_err", err_l, 0);

    foreach (vecs[i]) begin
      drive(0, vecs[i].v, vecs[i].d, vecs[i].f, 0);
      chk($sformatf("vec%0d_ready", i), ready_l, vecs[i].rdy);
      chk($sformatf("vec%0d_wr_en", i), wr_l, vecs[i].wr);
      chk($sformatf("vec%0d_wdata", i), wdata_l, vecs[i].wd_l);
      chk($sformatf("vec%0d_wdata_msb", i), wdata_m, vecs[i].wd_m);
      chk($sformatf("vec%0d_busy", i), busy_l, vecs[i].busy);
      chk($sformatf("vec%0d_idx", i), idx_l, vecs[i].idx);
      check_model();
      advance();
    end

    // Integrated with a 16-deep FIFO, no reads.
    fifo_mode = 1;
    written = 0;
    words[0] = 16'hA1B2; words[1] = 16'hC3D4; words[2] = 16'hE5F6;
    words[3] = 16'h0789; words[4] = 16'h1357;
    wi = 0;
    for (int c = 0; c < 22; c++) begin
      drive(0, wi < 5, (wi < 5) ? words[wi] : '0, fifo_q.size() == DEPTH, fifo_err);
      check_model();
      advance();
      if (acc_last) wi++;
    end
    chk("int_fifo_count", fifo_q.size(), DEPTH);
    chk("int_written", written, 16);
    chk("int_accepted", wi, 5);
    for (int k = 0; k < DEPTH; k++) begin
      w = words[k / R];
      chk($sformatf("int_fifo_entry%0d", k), fifo_q[k], w[(k % R)*W +: W]);
    end
    void'(fifo_q.pop_front());
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, '0, fifo_q.size() == DEPTH, fifo_err);
      check_model();
      advance();
    end
    chk("int_drain_written", written, 17);
    chk("int_drain_count", fifo_q.size(), DEPTH);
    chk("int_fifo_err", fifo_err, 0);
    chk("int_err_o", err_l, 0);
    fifo_mode = 0;

    // Reset mid-word, then sticky error.
    drive(1, 0, '0, 0, 0); check_model(); advance();
    drive(0, 1, 16'h4321, 0, 0); check_model(); advance();
    drive(0, 0, '0, 0, 0); check_model(); advance();
    drive(0, 0, '0, 0, 0); check_model(); advance();
    chk("mid_idx_before_rst", idx_l, 2);
    drive(1, 0, '0, 0, 0); check_model(); advance();
    drive(0, 0, '0, 0, 0);
    chk("mid_rst_busy", busy_l, 0);
    chk("mid_rst_ready", ready_l, 1);
    chk("mid_rst_idx", idx_l, 0);
    chk("mid_rst_err", err_l, 0);
    check_model(); advance();
    drive(0, 0, '0, 0, 1); check_model(); advance();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, '0, 0, 0);
      chk("err_sticky", err_l, 1);
      check_model(); advance();
    end
    drive(1, 0, '0, 0, 0); check_model(); advance();
    drive(0, 0, '0, 0, 0);
    chk("err_cleared", err_l, 0);
    check_model(); advance();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60), 16'($urandom),
            ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 2));
      check_model();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
